// File: rtl/knn_sort_ctrl.sv
// knn_sort_ctrl: sequences clear / stream / drain / read of the k-NN insertion sorter for one test point.
// Latency: start -> first result = 1 + 1 + n_train + 2 cycles without upstream bubbles; one result per cycle.
// Backpressure: dist_ready only in STREAM (bubbles legal); results stall on res_ready=0 with res_idx held.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start, i_n_train, i_k   job request (sampled only in IDLE), o_busy / o_done status
//   i_dist_in/_valid, o_dist_ready            upstream distance stream
//   o_sorter_clr/_valid/_dist/_done/_sel, i_sorter_idx   sorter control and select port
//   o_res_idx/_valid/_last, i_res_ready       downstream result stream
//   o_perf_cycles             busy-cycle counter, only when KNN_CTRL_PERF_EN is defined
module knn_sort_ctrl #(
    parameter int W    = 32,
    parameter int HW_K = 10
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic [W/2-1:0] i_n_train,
    input  logic [15:0]    i_k,
    output logic           o_busy,
    output logic           o_done,
    input  logic [W:0]     i_dist_in,
    input  logic           i_dist_valid,
    output logic           o_dist_ready,
    output logic           o_sorter_clr,
    output logic           o_sorter_valid,
    output logic [W:0]     o_sorter_dist,
    output logic           o_sorter_done,
    output logic [15:0]    o_sorter_sel,
    input  logic [W/2-1:0] i_sorter_idx,
    output logic [W/2-1:0] o_res_idx,
    output logic           o_res_valid,
    input  logic           i_res_ready,
    output logic           o_res_last
`ifdef KNN_CTRL_PERF_EN
    ,
    output logic [31:0]    o_perf_cycles
`endif
);

    localparam logic [15:0]    KMAX  = 16'(HW_K);
    localparam logic [W/2-1:0] ONE_N = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_READ
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_drain_ph;     // 0: last insert in flight, 1: freeze cycle
    logic [W/2-1:0] r_n_train;
    logic [15:0]    r_kq;
    logic [W/2-1:0] r_xfer_cnt;
    logic [15:0]    r_rd_cnt;
    logic           r_done;
    logic           r_sorter_done;
    logic [W:0]     r_sorter_dist;

    logic [15:0]    w_kq;
    logic           w_empty;
    logic           w_start_idle;
    logic           w_accept;
    logic           w_xfer;
    logic           w_last;
    logic           w_res_xfer;

    assign w_kq         = (i_k > KMAX) ? KMAX : i_k;
    assign w_empty      = (i_n_train == '0) || (w_kq == 16'd0);
    assign w_start_idle = (r_state == S_IDLE) && i_start;
    assign w_accept     = w_start_idle && !w_empty;
    assign w_xfer       = i_dist_valid && o_dist_ready;
    assign w_last       = (r_state == S_READ) && (r_rd_cnt == r_kq - 16'd1);
    assign w_res_xfer   = (r_state == S_READ) && i_res_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        o_busy         = 1'b1;
        o_dist_ready   = 1'b0;
        o_sorter_clr   = 1'b0;
        o_res_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (w_accept) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                o_sorter_clr = 1'b1;
                w_state_nxt  = S_STREAM;
            end
            S_STREAM: begin
                o_dist_ready = 1'b1;
                if (i_dist_valid && (r_xfer_cnt + ONE_N == r_n_train)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain_ph) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                o_res_valid = 1'b1;
                if (i_res_ready && w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drain_ph    <= 1'b0;
            r_n_train     <= '0;
            r_kq          <= 16'd0;
            r_xfer_cnt    <= '0;
            r_rd_cnt      <= 16'd0;
            r_done        <= 1'b0;
            r_sorter_done <= 1'b0;
            r_sorter_dist <= '0;
        end else begin
            r_done     <= (w_start_idle && w_empty) || (w_res_xfer && w_last);
            r_drain_ph <= (r_state == S_DRAIN) && !r_drain_ph;

            if (w_start_idle) begin
                r_n_train <= i_n_train;
                r_kq      <= w_kq;
                r_rd_cnt  <= 16'd0;
            end

            // Freeze stays asserted after readout so the slots remain readable
            // until the next job clears the sorter.
            if (w_accept) begin
                r_sorter_done <= 1'b0;
            end else if ((r_state == S_DRAIN) && !r_drain_ph) begin
                r_sorter_done <= 1'b1;
            end

            if (r_state == S_CLEAR) begin
                r_xfer_cnt <= '0;
            end else if (w_xfer) begin
                r_xfer_cnt <= r_xfer_cnt + ONE_N;
            end

            // Registered one cycle behind sorter_valid: the sorter registers
            // valid and inserts this distance on the following edge.
            if (w_xfer) begin
                r_sorter_dist <= i_dist_in;
            end

            if (w_res_xfer) begin
                r_rd_cnt <= w_last ? 16'd0 : r_rd_cnt + 16'd1;
            end
        end
    end

    assign o_done         = r_done;
    assign o_sorter_valid = w_xfer;
    assign o_sorter_dist  = r_sorter_dist;
    assign o_sorter_done  = r_sorter_done;
    assign o_sorter_sel   = r_rd_cnt;
    assign o_res_idx      = i_sorter_idx;
    assign o_res_last     = w_last;

`ifdef KNN_CTRL_PERF_EN
    logic [31:0] r_perf_cycles;

    // The accepting cycle counts as the first cycle of the job.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perf_cycles <= 32'd0;
        end else if (w_start_idle) begin
            r_perf_cycles <= 32'd1;
        end else if (o_busy && (r_perf_cycles != 32'hFFFF_FFFF)) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
        end
    end

    assign o_perf_cycles = r_perf_cycles;
`endif

endmodule

// File: doc/knn_sort_ctrl.md
# knn_sort_ctrl

Sequencing controller for the k-NN insertion sorter. For each test point it clears the sorter, streams `n_train` signed distances into it with the sorter's one-cycle valid/data skew, freezes the sorter, and then reads the `k` nearest training indices out through the sorter's select port as a valid/ready result stream. It sits between the distance-computation datapath (upstream) and the software-visible result interface (downstream).

## Interface
- `W`, 32: distance width; distances are W+1 bits signed, indices W/2 bits.
- `HW_K`, 10: number of sorter slots; `k` is clamped to this.
- `clk` in 1: clock.
- `rst` in 1: reset; one clock, reset is asynchronous and active-low.
- `start` in 1: one-cycle request to process one test point; sampled only in IDLE.
- `n_train` in W/2: number of training distances to stream; latched on accepted `start`.
- `k` in 16: neighbours to return; latched on accepted `start`, clamped to HW_K.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the last result is accepted, or on an empty job.
- `dist_in` in W+1: signed distance from the datapath.
- `dist_valid` / `dist_ready` in 1 / out 1: upstream handshake; transfer when both are high.
- `sorter_clr` out 1: synchronous active-high clear to the sorter.
- `sorter_valid` out 1: sorter valid.
- `sorter_dist` out W+1: registered distance to the sorter.
- `sorter_done` out 1: sorter freeze.
- `sorter_sel` out 16: slot select.
- `sorter_idx` in W/2: index returned by the sorter for `sorter_sel`.
- `res_idx` out W/2: result index.
- `res_valid` / `res_ready` out 1 / in 1: downstream handshake.
- `res_last` out 1: high with the result for slot k-1.
- `perf_cycles` out 32: present only with KNN_CTRL_PERF_EN.

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, READ.
- **IDLE**
  - If `start`: latch `n_train` and `kq = min(k, HW_K)`.
  - If either latched value is 0, pulse `done` next cycle and stay in IDLE.
  - Otherwise go to CLEAR.
- **CLEAR**: one cycle; `sorter_clr` = 1, which clears the sorter slots to all-ones and its index counter to 0. Then go to STREAM.
- **STREAM**
  - `dist_ready` = 1.
  - `sorter_valid = dist_valid & dist_ready` (combinational).
  - `sorter_dist` captures `dist_in` on every transfer and holds between transfers.
  - A 16-bit counter counts transfers. The transfer where the count reaches `n_train` moves the FSM to DRAIN.
  - Upstream bubbles (`dist_valid` = 0) are legal; the sorter index counter advances only on transfers, so indices equal transfer order 0..n_train-1.
- **DRAIN**
  - Two cycles; `dist_ready` = 0.
  - First cycle: the last distance is inserted.
  - Second cycle: `sorter_done` rises.
  - Then go to READ.
- **READ**
  - `sorter_done` = 1 and `dist_ready` = 0 throughout.
  - `sorter_sel` = read counter `r`, starting at 0.
  - `res_idx` = `sorter_idx` (combinational).
  - `res_valid` = 1; `res_last` = (r == kq-1).
  - On `res_ready`, `r` increments.
  - On the transfer with `res_last`: `done` pulses, `sorter_done` stays high (results remain frozen), and the FSM goes to IDLE.
- `start` outside IDLE is ignored.
- `n_train` < `kq`: unused slots return the sorter's cleared index 0. This is not flagged.

## Timing
- Reset values, all outputs: `busy`, `done`, `dist_ready`, `sorter_valid`, `sorter_done`, `res_valid`, `res_last` = 0; `sorter_clr` = 0; `sorter_dist` = 0; `sorter_sel` = 0; `res_idx` follows `sorter_idx`; `perf_cycles` = 0.
- Reset is asserted asynchronously and released synchronously. Reset mid-job returns to IDLE.
- `sorter_valid` leads `sorter_dist` by exactly one cycle, matching the sorter's registered-valid insertion.
- Minimum job latency: `start` → first `res_valid` = 1 (IDLE) + 1 (CLEAR) + `n_train` + 2 cycles, with no upstream bubbles.
- Readout: one result per cycle while `res_ready` is held high.

## Configuration
- `KNN_CTRL_PERF_EN` defined:
  - 32-bit `perf_cycles` clears on an accepted `start` and counts every cycle with `busy` = 1.
  - It holds its value after `done` and saturates at 0xFFFFFFFF.
- Not defined: the port is absent; no counter logic is built.

## Test plan
- `n_train`=5, `k`=3, distances 40, 10, 30, 20, 50, no bubbles → results 1, 3, 2; `res_last` on the third; `done` 12 cycles after `start` with `res_ready` tied high.
- Same job with `dist_valid` low on alternate cycles → same results; the `sorter_valid` and `sorter_dist` skew is preserved on every transfer.
- `k`=15, `HW_K`=10, `n_train`=12 → exactly 10 results, `res_last` with `sorter_sel`=9.
- `n_train`=0 (and separately `k`=0) → no `sorter_clr`, no `res_valid`, `done` pulse 1 cycle after `start`.
- `res_ready` toggling 1,0,0,1 → `res_idx` is stable while stalled and the sequence is unchanged; `start` pulsed during READ is ignored.
- `rst` asserted mid-STREAM → all outputs go to reset values immediately. A new job afterwards returns correct results. With `KNN_CTRL_PERF_EN`, the first test's `perf_cycles` = 12.
